mtr_drv: RTL and testbench

MTR_DRV -- requirements
Module: mtr_drv

---
 rtl/mtr_drv.sv | 165 ++++++++++++++++
 tb/tb_mtr_drv.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mtr_drv.sv
// Dual-channel H-bridge PWM driver with per-channel dead-time insertion.
// An 11-bit free-running counter sets a 2048-clock PWM period. Speed
// commands are sampled once per period and compared against the counter.
// A non-overlap FSM then guarantees 32 clocks with both sides off around
// every switch.
// Optional feature macro: MTR_SLEW_EN. When it is defined, each per-period
// latch moves the sampled speed by at most 64 counts.

module mtr_drv_chan (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pwm1,
  output logic pwm2
);

  typedef enum logic [1:0] {DEAD, DRV_HI, DRV_LO} drv_state_e;

  drv_state_e state, state_nxt;
  logic       target, target_nxt;
  logic [4:0] timer, timer_nxt;

  // Next-state logic: any disagreement with raw restarts the dead interval.
  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    timer_nxt  = timer;
    unique case (state)
      DRV_HI: if (!raw) begin
        state_nxt  = DEAD;
        target_nxt = 1'b0;
        timer_nxt  = '0;
      end
      DRV_LO: if (raw) begin
        state_nxt  = DEAD;
        target_nxt = 1'b1;
        timer_nxt  = '0;
      end
      DEAD: begin
        if (raw != target) begin
          target_nxt = raw;
          timer_nxt  = '0;
        end else if (timer == 5'd31) begin
          state_nxt = target ? DRV_HI : DRV_LO;
        end else begin
          timer_nxt = timer + 5'd1;
        end
      end
      default: begin
        state_nxt  = DEAD;
        target_nxt = raw;
        timer_nxt  = '0;
      end
    endcase
  end

  // State register; the drive outputs are registered decodes of next state.
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= DEAD;
      target <= 1'b1;
      timer  <= '0;
      pwm1   <= 1'b0;
      pwm2   <= 1'b0;
    end else begin
      state  <= state_nxt;
      target <= target_nxt;
      timer  <= timer_nxt;
      pwm1   <= (state_nxt == DRV_HI);
      pwm2   <= (state_nxt == DRV_LO);
    end
  end

endmodule

module mtr_drv (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [10:0] lft_spd,
  input  logic signed [10:0] rght_spd,
  output logic               lftPWM1,
  output logic               lftPWM2,
  output logic               rghtPWM1,
  output logic               rghtPWM2,
  output logic               prd_strt
);

  logic [10:0]        cnt, cnt_nxt;
  logic               wrap;
  logic signed [10:0] lft_q, rght_q, lft_nxt, rght_nxt;
  logic [10:0]        lft_duty, rght_duty;
  logic               lft_raw, rght_raw;

`ifdef MTR_SLEW_EN
  // Step cur toward tgt by at most 64; 12-bit math so the difference never wraps.
  function automatic logic signed [10:0] slew_step(input logic signed [10:0] cur,
                                                   input logic signed [10:0] tgt);
    logic signed [11:0] cur_w, diff;
    cur_w = {cur[10], cur};
    diff  = {tgt[10], tgt} - cur_w;
    if (diff > 12'sd64)       slew_step = 11'(cur_w + 12'sd64);
    else if (diff < -12'sd64) slew_step = 11'(cur_w - 12'sd64);
    else                      slew_step = tgt;
  endfunction
`endif

  assign wrap    = (cnt == 11'd2047);
  assign cnt_nxt = cnt + 11'd1;

  // Speeds only change on the wrap edge so a period never sees a mid-cycle step.
  always_comb begin
`ifdef MTR_SLEW_EN
    lft_nxt  = wrap ? slew_step(lft_q, lft_spd)   : lft_q;
    rght_nxt = wrap ? slew_step(rght_q, rght_spd) : rght_q;
`else
    lft_nxt  = wrap ? lft_spd  : lft_q;
    rght_nxt = wrap ? rght_spd : rght_q;
`endif
  end

  // Offset-binary duty; raw is evaluated on the upcoming counter and duty so
  // that the registered drive outputs line up with the counter value they
  // belong to.
  always_comb begin
    lft_duty  = {~lft_nxt[10], lft_nxt[9:0]};
    rght_duty = {~rght_nxt[10], rght_nxt[9:0]};
    lft_raw   = (cnt_nxt < lft_duty);
    rght_raw  = (cnt_nxt < rght_duty);
  end

  // Period counter, latched speeds and period-start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      lft_q    <= '0;
      rght_q   <= '0;
      prd_strt <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      lft_q    <= lft_nxt;
      rght_q   <= rght_nxt;
      prd_strt <= wrap;
    end
  end

  mtr_drv_chan u_lft (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (lft_raw),
    .pwm1  (lftPWM1),
    .pwm2  (lftPWM2)
  );

  mtr_drv_chan u_rght (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (rght_raw),
    .pwm1  (rghtPWM1),
    .pwm2  (rghtPWM2)
  );

endmodule

// File: tb/tb_mtr_drv.sv
// Scoreboard bench for mtr_drv. The reference model tracks the period
// counter and the latched speeds. For each channel it tracks how long the
// ideal PWM level (cnt < duty) has been unchanged. A side is driven only
// once that level has held for 33 consecutive cycles: 1 switching cycle
// plus 32 dead cycles.

module tb_mtr_drv;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [10:0] lft_spd, rght_spd;
  logic               lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, prd_strt;

  typedef struct packed {
    logic l1, l2, r1, r2, prd;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state.
  int m_cnt;
  int m_lat  [2];
  int run_val[2];
  int run_len[2];

  mtr_drv dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .lft_spd  (lft_spd),
    .rght_spd (rght_spd),
    .lftPWM1  (lftPWM1),
    .lftPWM2  (lftPWM2),
    .rghtPWM1 (rghtPWM1),
    .rghtPWM2 (rghtPWM2),
    .prd_strt (prd_strt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, wanted %0d (t=%0t, model cnt=%0d)", name, act, req, $time, m_cnt);
    end
  endtask

  function automatic int slew_model(input int cur, input int tgt);
`ifdef MTR_SLEW_EN
    if (tgt - cur > 64) return cur + 64;
    if (cur - tgt > 64) return cur - 64;
`endif
    return tgt;
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    for (int c = 0; c < 2; c++) begin
      m_lat[c]   = 0;
      run_val[c] = 1;   // cnt 0 < duty 1024
      run_len[c] = 1;
    end
  endtask

  // Advance the model across one rising edge and queue the expected outputs.
  task automatic model_edge();
    exp_t e;
    int   lvl;
    if (m_cnt == 2047) begin
      m_lat[0] = slew_model(m_lat[0], int'(lft_spd));
      m_lat[1] = slew_model(m_lat[1], int'(rght_spd));
    end
    m_cnt = (m_cnt + 1) % 2048;
    for (int c = 0; c < 2; c++) begin
      lvl = (m_cnt < m_lat[c] + 1024) ? 1 : 0;
      if (lvl == run_val[c]) begin
        if (run_len[c] < 1000) run_len[c]++;
      end else begin
        run_val[c] = lvl;
        run_len[c] = 1;
      end
    end
    e.l1  = (run_val[0] == 1) && (run_len[0] >= 33);
    e.l2  = (run_val[0] == 0) && (run_len[0] >= 33);
    e.r1  = (run_val[1] == 1) && (run_len[1] >= 33);
    e.r2  = (run_val[1] == 0) && (run_len[1] >= 33);
    e.prd = (m_cnt == 0);
    exp_q.push_back(e);
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
    end
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_lftPWM1"},  lftPWM1,  0);
    check({tag, "_lftPWM2"},  lftPWM2,  0);
    check({tag, "_rghtPWM1"}, rghtPWM1, 0);
    check({tag, "_rghtPWM2"}, rghtPWM2, 0);
    check({tag, "_prd_strt"}, prd_strt, 0);
  endtask

  function automatic logic signed [10:0] pick_speed();
    case ($urandom_range(0, 7))
      0:       return -11'sd1024;
      1:       return 11'sd1023;
      2:       return 11'sd0;
      default: return 11'($urandom);
    endcase
  endfunction

  // Monitor: every cycle with a queued expectation, compare the DUT outputs.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("lftPWM1",  lftPWM1,  e.l1);
      check("lftPWM2",  lftPWM2,  e.l2);
      check("rghtPWM1", rghtPWM1, e.r1);
      check("rghtPWM2", rghtPWM2, e.r2);
      check("prd_strt", prd_strt, e.prd);
      check("lft_overlap",  lftPWM1 & lftPWM2,   0);
      check("rght_overlap", rghtPWM1 & rghtPWM2, 0);
    end
  end

  initial begin
    rst_n    = 1'b0;
    lft_spd  = '0;
    rght_spd = '0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check_all_low("in_reset");
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Zero speed: symmetric 992-clock pulses on each side.
    run_cycles(2 * 2048);

    // Full reverse for three periods.
    lft_spd = -11'sd1024;
    run_cycles(3 * 2048);

    // Full forward on the left; right steps 0 -> 500 in mid-period at cnt 600.
    lft_spd = 11'sd1023;
    for (int i = 0; i < 2048 && m_cnt != 600; i++) run_cycles(1);
    rght_spd = 11'sd500;
    run_cycles(2 * 2048 + 600);

    // Asynchronous reset in the middle of a period.
    rght_spd = -11'sd300;
    run_cycles(777);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_all_low("async_reset");
    repeat (2) begin
      @(negedge clk);
      check_all_low("held_reset");
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_cycles(2 * 2048);

    // Random speeds, changed at arbitrary points of the period.
    for (int i = 0; i < 20 * 2048; i++) begin
      if ($urandom_range(0, 511) == 0) lft_spd  = pick_speed();
      if ($urandom_range(0, 511) == 0) rght_spd = pick_speed();
      run_cycles(1);
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
